noc_rr_switch: RTL and testbench
================================

Name: noc_rr_switch

Overview:
- Network-side endpoint of the cpu<->noc valid/ready link.
- Accepts 64-bit beats from CPU_NB cpu ports and buffers each port in a small FIFO.
- Routes each beat to the destination cpu port named in its header byte.
- Arbitrates round-robin per destination; drives the noc->cpu valid/ready outputs back to the cpus.

Parameters:
- CPU_NB, 4, number of cpu ports (2..16).
- DATA_W, 64, beat width in bits.
- FIFO_DEPTH, 2, entries per input FIFO (power of two, >=2).
- DEST_LSB, 56, LSB of the 8-bit destination field within a beat.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- data_cpu_to_noc_rdy  output  CPU_NB x 1  per-port input ready.
- data_cpu_to_noc_vld  input  CPU_NB x 1  per-port input valid.
- data_cpu_to_noc  input  CPU_NB x DATA_W  per-port input beat.
- data_noc_to_cpu_rdy  input  CPU_NB x 1  per-port output ready from cpu.
- data_noc_to_cpu_vld  output  CPU_NB x 1  per-port output valid.
- data_noc_to_cpu  output  CPU_NB x DATA_W  per-port output beat.
- drop_cnt  output  32  count of beats dropped for bad destination.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset: all FIFOs empty; all data_noc_to_cpu_vld=0; data_noc_to_cpu=0; drop_cnt=0; all RR pointers=CPU_NB-1 (port 0 highest priority first); data_cpu_to_noc_rdy=0 while rst=1, 1 after.
- Reset mid-operation: all buffered and in-flight beats are discarded; no partial output.
- Transfer rule: a beat moves on any edge where vld&&rdy. Once an output asserts vld, data is held stable until rdy.
- Input side:
  - data_cpu_to_noc_rdy[i] = !fifo_full[i], registered-count based, no combinational dependence on vld.
  - Accept when vld&&rdy. A push and a pop in the same cycle on a full FIFO is not allowed (rdy is already 0).
  - Push on empty FIFO: the head is visible the following cycle.
- Destination: dest = head[DEST_LSB+7:DEST_LSB], unsigned.
  - dest >= CPU_NB: the head is popped in one cycle with no output, and drop_cnt increments, saturating at 2^32-1.
  - Dropped beats do not consume arbitration slots.
- Output register per destination j:
  - Holds 1 beat. It may load when empty, or when data_noc_to_cpu_rdy[j]=1 in the same cycle (back-to-back, 1 beat/cycle).
- Arbitration per destination j:
  - Candidates are inputs whose FIFO is non-empty and whose head dest==j.
  - The grant goes to the first candidate searching from ptr[j]+1 upward, modulo CPU_NB.
  - On grant: pop that input, load the output register, set ptr[j]=granted index. ptr[j] is unchanged without a grant.
- Each input is granted to at most one destination per cycle, since it has only one head.
- Self-routing (dest==i) is legal.
- Latency: beat accepted at edge k on an idle path gives output vld=1 after edge k+1 (2-cycle pipe). Sustained throughput per uncontended path is 1 beat/cycle.
- Ordering: beats from a given input to a given output stay in order. There is no ordering guarantee across inputs.
- Backpressure: output rdy=0 holds the output register. Heads then stall, the FIFO fills, and input rdy drops after FIFO_DEPTH further beats (plus 1 in the output register).
- No combinational path from any *_vld to any *_rdy.

Test Plan:
- Reset: hold rst 5 cycles with random vld -> all noc_to_cpu_vld=0, drop_cnt=0, cpu_to_noc_rdy=0. Release -> rdy=1 on all ports the next cycle.
- Single path: cpu0 sends 0x01_00..00AB (dest 1) at edge k, all rdy=1 -> data_noc_to_cpu_vld[1]=1 with data 0x0100..00AB after edge k+1, for exactly 1 cycle.
- Contention: cpu0..3 each stream 4 beats to dest 2, out rdy=1 -> port 2 receives the source order 0,1,2,3,0,1,2,3,... with 1 beat/cycle and no loss. Per-source payload order is preserved.
- Backpressure: dest 3 rdy=0, cpu1 streams to dest 3 with FIFO_DEPTH=2 -> exactly 3 beats accepted, then rdy[1]=0. Raising rdy drains all 3 in order with no duplicates.
- Bad destination: cpu2 sends dest 0xFF x5 -> no output vld, drop_cnt=5, cpu2 is never stalled by drops. A following beat to dest 0 is delivered normally.
- Async reset mid-stream: assert rst between edges while 3 beats are buffered -> outputs clear immediately (before the next edge), and nothing is emitted after release.

Source files
------------

// File: rtl/noc_rr_switch.sv
// noc_rr_switch: network-side endpoint of the cpu<->noc valid/ready link.
// Each cpu port feeds a small input FIFO. The header byte of the FIFO head picks
// a destination port. A round-robin arbiter per destination fills a one-beat
// output register. Heads with an out-of-range destination are dropped and counted.
module noc_rr_switch #(
  parameter int unsigned CPU_NB     = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DEST_LSB   = 56
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [CPU_NB-1:0]             data_cpu_to_noc_rdy_o,
  input  logic [CPU_NB-1:0]             data_cpu_to_noc_vld_i,
  input  logic [CPU_NB-1:0][DATA_W-1:0] data_cpu_to_noc_i,
  input  logic [CPU_NB-1:0]             data_noc_to_cpu_rdy_i,
  output logic [CPU_NB-1:0]             data_noc_to_cpu_vld_o,
  output logic [CPU_NB-1:0][DATA_W-1:0] data_noc_to_cpu_o,
  output logic [31:0]                   drop_cnt_o
);

  localparam int unsigned PtrW  = $clog2(CPU_NB);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  // Input FIFO state
  logic [DATA_W-1:0] mem_q    [CPU_NB][FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q [CPU_NB];
  logic [AddrW-1:0]  wr_ptr_d [CPU_NB];
  logic [AddrW-1:0]  rd_ptr_q [CPU_NB];
  logic [AddrW-1:0]  rd_ptr_d [CPU_NB];
  logic [CntW-1:0]   cnt_q    [CPU_NB];
  logic [CntW-1:0]   cnt_d    [CPU_NB];

  // Low during reset and for the first edge after it, so inputs see rdy=0 in reset
  logic alive_q;

  // Output registers, arbitration pointers and drop counter
  logic [CPU_NB-1:0]             out_vld_q, out_vld_d;
  logic [CPU_NB-1:0][DATA_W-1:0] out_data_q, out_data_d;
  logic [PtrW-1:0]               rr_ptr_q [CPU_NB];
  logic [PtrW-1:0]               rr_ptr_d [CPU_NB];
  logic [31:0]                   drop_cnt_q, drop_cnt_d;

  // Per-input head decode
  logic [CPU_NB-1:0] fifo_full, fifo_nonempty, head_bad, push, pop;
  logic [DATA_W-1:0] head      [CPU_NB];
  logic [7:0]        head_dest [CPU_NB];
  logic [PtrW-1:0]   gnt_src   [CPU_NB];

  // Input readiness from registered occupancy only, and head/destination decode
  always_comb begin
    for (int i = 0; i < int'(CPU_NB); i++) begin
      fifo_full[i]             = (cnt_q[i] == FullCnt);
      fifo_nonempty[i]         = (cnt_q[i] != '0);
      head[i]                  = mem_q[i][rd_ptr_q[i]];
      head_dest[i]             = head[i][DEST_LSB +: 8];
      head_bad[i]              = fifo_nonempty[i] && (32'(head_dest[i]) >= CPU_NB);
      data_cpu_to_noc_rdy_o[i] = alive_q && !fifo_full[i];
      push[i]                  = data_cpu_to_noc_rdy_o[i] && data_cpu_to_noc_vld_i[i];
    end
  end

  // Round-robin arbitration per destination; bad heads pop without taking a slot
  always_comb begin
    int   idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    pop        = head_bad;
    out_vld_d  = out_vld_q & ~data_noc_to_cpu_rdy_i;
    out_data_d = out_data_q;
    for (int j = 0; j < int'(CPU_NB); j++) begin
      rr_ptr_d[j] = rr_ptr_q[j];
      gnt_src[j]  = '0;
      found       = 1'b0;
      // Search starts just after the last winner and wraps
      for (int k = 1; k <= int'(CPU_NB); k++) begin
        idx = (int'(rr_ptr_q[j]) + k) % int'(CPU_NB);
        if (!found && fifo_nonempty[idx] && !head_bad[idx] && (head_dest[idx] == 8'(j))) begin
          found      = 1'b1;
          gnt_src[j] = PtrW'(idx);
        end
      end
      // Load when the register is empty or being drained this cycle
      if (found && (!out_vld_q[j] || data_noc_to_cpu_rdy_i[j])) begin
        pop[gnt_src[j]] = 1'b1;
        out_vld_d[j]    = 1'b1;
        out_data_d[j]   = head[gnt_src[j]];
        rr_ptr_d[j]     = gnt_src[j];
      end
    end
  end

  // FIFO pointer and occupancy next-state; push and pop on a full FIFO cannot coincide
  always_comb begin
    for (int i = 0; i < int'(CPU_NB); i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + AddrW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AddrW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
  end

  // Saturating drop counter, several inputs may drop in the same cycle
  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < int'(CPU_NB); i++) begin
      sum = sum + 33'(head_bad[i]);
    end
    drop_cnt_d = sum[32] ? '1 : sum[31:0];
  end

  // Control state with asynchronous reset; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q    <= 1'b0;
      out_vld_q  <= '0;
      out_data_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(CPU_NB); i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        rr_ptr_q[i] <= PtrW'(CPU_NB - 1);
      end
    end else begin
      alive_q    <= 1'b1;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < int'(CPU_NB); i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        rr_ptr_q[i] <= rr_ptr_d[i];
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(CPU_NB); i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= data_cpu_to_noc_i[i];
      end
    end
  end

  assign data_noc_to_cpu_vld_o = out_vld_q;
  assign data_noc_to_cpu_o     = out_data_q;
  assign drop_cnt_o            = drop_cnt_q;

endmodule

// File: tb/tb_noc_rr_switch.sv
// Testbench for noc_rr_switch: scoreboard of per (source, destination) queues
// filled from accepted input beats and drained by an output monitor.
module tb_noc_rr_switch;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]        in_rdy, in_vld, out_rdy, out_vld;
  logic [N-1:0][63:0]  din, dout;
  logic [31:0]         drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] stim_q [N][$];
  logic [63:0] exp_q  [N*N][$];
  int          rx_src_q [N][$];
  int          rx_cyc_q [N][$];
  int          rx_cnt [N];
  int          acc_cnt [N];
  int          stall_cnt [N];
  int          exp_drop = 0;
  int          vld_seen = 0;
  logic [N-1:0]       hold;
  logic [N-1:0][63:0] hold_data;
  bit drv_en  = 1'b0;
  bit bubbles = 1'b0;

  noc_rr_switch #(
    .CPU_NB    (N),
    .DATA_W    (64),
    .FIFO_DEPTH(2),
    .DEST_LSB  (56)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_cpu_to_noc_rdy_o(in_rdy),
    .data_cpu_to_noc_vld_i(in_vld),
    .data_cpu_to_noc_i    (din),
    .data_noc_to_cpu_rdy_i(out_rdy),
    .data_noc_to_cpu_vld_o(out_vld),
    .data_noc_to_cpu_o    (dout),
    .drop_cnt_o           (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] make_beat(input int dest, input int src, input int seq);
    logic [19:0] r;
    r = 20'($urandom);
    return {8'(dest), 4'(src), r, 32'(seq)};
  endfunction

  function automatic bit idle();
    bit b;
    b = 1'b1;
    if (in_vld != '0 || out_vld != '0) b = 1'b0;
    for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) b = 1'b0;
    for (int k = 0; k < N*N; k++) if (exp_q[k].size() != 0) b = 1'b0;
    return b;
  endfunction

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!idle() && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk(name, 64'(idle()), 64'd1);
  endtask

  // Input monitor: every accepted beat becomes an expectation (or an expected drop)
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (in_vld[i] && !in_rdy[i]) stall_cnt[i]++;
        if (in_vld[i] && in_rdy[i]) begin
          acc_cnt[i]++;
          if (din[i][63:56] < 8'(N)) exp_q[i*N + int'(din[i][63:56])].push_back(din[i]);
          else exp_drop++;
        end
      end
    end
  end

  // Output monitor: compares delivered beats in per-path order and checks hold stability
  always @(negedge clk) begin : omon
    int src;
    if (rst) begin
      hold = '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (out_vld[j]) vld_seen++;
        if (hold[j]) begin
          chk($sformatf("port%0d_hold_vld", j), 64'(out_vld[j]), 64'd1);
          chk($sformatf("port%0d_hold_data", j), dout[j], hold_data[j]);
        end
        if (out_vld[j] && out_rdy[j]) begin
          src = int'(dout[j][55:52]);
          rx_cnt[j]++;
          rx_src_q[j].push_back(src);
          rx_cyc_q[j].push_back(cyc);
          if (src >= N || exp_q[src*N + j].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL port%0d_unexpected actual=0x%0h required=none", j, dout[j]);
          end else begin
            chk($sformatf("port%0d_beat", j), dout[j], exp_q[src*N + j].pop_front());
          end
        end
        hold[j]      = out_vld[j] && !out_rdy[j];
        hold_data[j] = dout[j];
      end
    end
  end

  // Stream driver: presents the head of each stim queue, advances on acceptance
  initial begin : driver
    logic [N-1:0] took;
    forever begin
      @(negedge clk);
      took = in_vld & in_rdy & {N{!rst}};
      @(posedge clk); #1;
      if (drv_en) begin
        for (int i = 0; i < N; i++) begin
          if (took[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
          if (stim_q[i].size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            in_vld[i] = 1'b1;
            din[i]    = stim_q[i][0];
          end else begin
            in_vld[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, rxb, vb, n, d;
    in_vld  = '0;
    din     = '0;
    out_rdy = '1;

    // Reset held with random input activity
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_vld = N'($urandom);
      for (int i = 0; i < N; i++) din[i] = {$urandom, $urandom};
      @(negedge clk);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    in_vld = '0;
    @(posedge clk); #1;
    chk("release_in_rdy", 64'(in_rdy), 64'hF);

    // Single path: cpu0 -> cpu1, two-cycle pipe, one-cycle pulse
    din[0] = 64'h0100_0000_0000_00AB;
    in_vld[0] = 1'b1;
    @(posedge clk); #1;
    in_vld[0] = 1'b0;
    chk("sp_vld_after_k", 64'(out_vld), 64'd0);
    @(posedge clk); #1;
    chk("sp_vld_after_k1", 64'(out_vld), 64'h2);
    chk("sp_data", dout[1], 64'h0100_0000_0000_00AB);
    @(posedge clk); #1;
    chk("sp_vld_after_k2", 64'(out_vld), 64'd0);

    // Contention: all sources stream 4 beats to port 2
    rx_src_q[2].delete();
    rx_cyc_q[2].delete();
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 4; s++) stim_q[i].push_back(make_beat(2, i, s));
    drv_en = 1'b1;
    drain("cont_drain", 200);
    chk("cont_count", 64'(rx_src_q[2].size()), 64'd16);
    for (int k = 0; k < rx_src_q[2].size() && k < 16; k++)
      chk($sformatf("cont_src%0d", k), 64'(rx_src_q[2][k]), 64'(k % 4));
    if (rx_cyc_q[2].size() >= 16)
      chk("cont_rate", 64'(rx_cyc_q[2][15] - rx_cyc_q[2][0]), 64'd15);

    // Backpressure: port 3 stalled, cpu1 streams to it
    out_rdy = 4'b0111;
    base = acc_cnt[1];
    rxb  = rx_cnt[3];
    for (int s = 0; s < 5; s++) stim_q[1].push_back(make_beat(3, 1, s));
    repeat (12) begin @(posedge clk); #1; end
    chk("bp_accepted", 64'(acc_cnt[1] - base), 64'd3);
    chk("bp_in_rdy", 64'(in_rdy[1]), 64'd0);
    chk("bp_out_vld", 64'(out_vld[3]), 64'd1);
    out_rdy = '1;
    drain("bp_drain", 100);
    chk("bp_delivered", 64'(rx_cnt[3] - rxb), 64'd5);

    // Bad destination: five drops then one good beat to port 0
    base = stall_cnt[2];
    rxb  = rx_cnt[0];
    vb   = vld_seen;
    for (int s = 0; s < 5; s++) stim_q[2].push_back(make_beat(8'hFF, 2, s));
    stim_q[2].push_back(make_beat(0, 2, 5));
    drain("bad_drain", 100);
    chk("bad_stalls", 64'(stall_cnt[2] - base), 64'd0);
    chk("bad_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("bad_good_rx", 64'(rx_cnt[0] - rxb), 64'd1);
    chk("bad_vld_cycles", 64'(vld_seen - vb), 64'd1);

    // Random traffic with bubbles, random destinations and random output backpressure
    bubbles = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 40; s++) begin
        n = $urandom_range(0, 9);
        if (n < 8) d = $urandom_range(0, N - 1);
        else d = N + $urandom_range(0, 255 - N);
        stim_q[i].push_back(make_beat(d, i, 100 + s));
      end
    end
    repeat (300) begin
      @(posedge clk); #1;
      out_rdy = N'($urandom);
    end
    out_rdy = '1;
    drain("rand_drain", 600);
    chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // Asynchronous reset with three beats buffered on the cpu0 -> cpu1 path
    bubbles = 1'b0;
    out_rdy = 4'b1101;
    base = acc_cnt[0];
    for (int s = 0; s < 3; s++) stim_q[0].push_back(make_beat(1, 0, 200 + s));
    n = 0;
    while (acc_cnt[0] - base < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_buffered", 64'(acc_cnt[0] - base), 64'd3);
    chk("ar_pre_vld", 64'(out_vld[1]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_out_vld", 64'(out_vld), 64'd0);
    for (int j = 0; j < N; j++) chk($sformatf("ar_data%0d", j), dout[j], 64'd0);
    chk("ar_in_rdy", 64'(in_rdy), 64'd0);
    drv_en = 1'b0;
    in_vld = '0;
    for (int i = 0; i < N; i++) stim_q[i].delete();
    for (int k = 0; k < N*N; k++) exp_q[k].delete();
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    out_rdy = '1;
    vb = vld_seen;
    repeat (10) begin @(posedge clk); #1; end
    chk("ar_no_emit", 64'(vld_seen - vb), 64'd0);
    chk("ar_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
